// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle SRL/SRA unit that shifts one bit per clock.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    launch request, honoured only in IDLE or DONE
//   arith    1 = sign-fill (SRA), 0 = zero-fill (SRL); captured with start
//   data_in  operand, captured with start
//   shamt    shift amount 0..WIDTH-1, captured with start
//   busy     high while a shift is in progress
//   done     one-cycle pulse; q is valid from this cycle on
//   q        result, held until the next done
module serial_right_shifter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               arith,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   q
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               fill_q, fill_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   sreg_shifted;
  logic               accept;

  assign sreg_shifted = {fill_q, sreg_q[WIDTH-1:1]};
  // A start during SHIFT is dropped, not queued.
  assign accept = start && (state_q != StShift);

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    q_d     = q_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          sreg_d = data_in;
          cnt_d  = shamt;
          // Fill bit is frozen here so arith/data_in may change mid-operation.
          fill_d = arith & data_in[WIDTH-1];
          if (shamt == '0) begin
            state_d = StDone;
            q_d     = data_in;
          end else begin
            state_d = StShift;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        sreg_d = sreg_shifted;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = StDone;
          // q only ever sees the final value, never intermediate shifts.
          q_d     = sreg_shifted;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered decodes of the next state keep busy/done aligned with state_q.
    busy_d = (state_d == StShift);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign q    = q_q;

endmodule

// File: tb/tb_serial_right_shifter.sv
// Directed bench for serial_right_shifter with hand-computed expected results.
module tb_serial_right_shifter;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        arith;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] q;

  int n_cmp;
  int n_err;

  serial_right_shifter #(
    .WIDTH  (32),
    .SHAMT_W(5)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .arith  (arith),
    .data_in(data_in),
    .shamt  (shamt),
    .busy   (busy),
    .done   (done),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents an op for one edge, then scrambles the inputs to prove they were captured.
  task automatic launch(input logic [31:0] d, input logic [4:0] s, input logic a);
    start   = 1'b1;
    data_in = d;
    shamt   = s;
    arith   = a;
    @(posedge clk);
    #1;
    start   = 1'b0;
    data_in = 32'h5555_AAAA;
    shamt   = 5'd17;
    arith   = ~a;
  endtask

  // Observes cycles 1..ncyc after a start edge; optionally pulses start in cycle inj.
  task automatic watch(input int ncyc, input int inj, input logic [31:0] injd,
                       input logic [31:0] q_prev, output int done_cyc, output int busy_cyc,
                       output int done_cnt, output int q_early);
    done_cyc = 0;
    busy_cyc = 0;
    done_cnt = 0;
    q_early  = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (busy === 1'b1) busy_cyc++;
      if (done_cyc == 0 && q !== q_prev) q_early++;
      if (c == inj) begin
        start   = 1'b1;
        data_in = injd;
        shamt   = 5'd2;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [31:0] d, input logic [4:0] s,
                        input logic a, input logic [31:0] exp, input int inj);
    logic [31:0] qp;
    int dc, bc, cnt, qe;
    qp = q;
    launch(d, s, a);
    watch(int'(s) + 5, inj, 32'hFFFF_FFFF, qp, dc, bc, cnt, qe);
    check({tag, "_latency"}, dc, int'(s) + 1);
    check({tag, "_busy_cycles"}, bc, int'(s));
    check({tag, "_done_count"}, cnt, 1);
    check({tag, "_q_early"}, qe, 0);
    check({tag, "_q"}, q, exp);
  endtask

  initial begin
    int dc, bc, cnt, qe, c_done;
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    arith   = 1'b0;
    data_in = '0;
    shamt   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q", q, 32'h0);
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("srl4",       32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 0);
    run_op("sra4_neg",   32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 0);
    run_op("sra4_pos",   32'h7000_0000, 5'd4,  1'b1, 32'h0700_0000, 0);
    run_op("zero_shift", 32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, 0);
    run_op("sra31",      32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 0);
    run_op("srl31",      32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 0);
    run_op("srl7",       32'hA5A5_A5A5, 5'd7,  1'b0, 32'h014B_4B4B, 0);
    run_op("sra7",       32'hA5A5_A5A5, 5'd7,  1'b1, 32'hFF4B_4B4B, 0);
    // Second start with different data in cycle 2 of a shamt=8 op must be ignored.
    run_op("busy_start", 32'h1234_5678, 5'd8,  1'b0, 32'h0012_3456, 2);

    // Back-to-back: start held in the DONE cycle launches the next op with no gap.
    launch(32'hF000_0000, 5'd3, 1'b1);
    c_done = 0;
    for (int c = 1; c <= 10; c++) begin
      if (done === 1'b1) begin
        c_done = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("b2b_a_latency", c_done, 4);
    check("b2b_a_q", q, 32'hFE00_0000);
    launch(32'h0000_FF00, 5'd5, 1'b0);
    watch(9, 0, 32'h0, 32'hFE00_0000, dc, bc, cnt, qe);
    check("b2b_b_latency", dc, 6);
    check("b2b_b_busy_cycles", bc, 5);
    check("b2b_b_done_count", cnt, 1);
    check("b2b_b_q_early", qe, 0);
    check("b2b_b_q", q, 32'h0000_07F8);

    // Reset in cycle 3 of a shamt=10 op aborts immediately.
    launch(32'h0000_0400, 5'd10, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_q", q, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    watch(14, 0, 32'h0, 32'h0, dc, bc, cnt, qe);
    check("abort_no_done", cnt, 0);
    check("abort_no_busy", bc, 0);
    check("abort_q_held", q, 32'h0);
    run_op("post_abort", 32'h0000_0400, 5'd10, 1'b0, 32'h0000_0001, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
